// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone master/slave blocks: FSM encoding,
// default widths and the byte-select width derivation.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_LEN_W   = 8;
    localparam int DEF_TIMEOUT = 255;

    function automatic int selWidth(input int dataW);
        return dataW / 8;
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Per-beat stall counter: cleared by iLoad, advanced by iInc, flags expiry on
// the stalled cycle that brings it to TIMEOUT. TIMEOUT=0 never expires.
module wb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic iCLK,
    input  logic iRSTn,
    input  logic iLoad,
    input  logic iInc,
    output logic oExpire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit ENABLE = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] LAST = ENABLE ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            cnt <= '0;
        end else if (iLoad) begin
            cnt <= '0;
        end else if (iInc && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Expiry is combinational so the abort lands on the same edge as the last stall.
    assign oExpire = ENABLE && iInc && (cnt == LAST);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone classic-cycle burst master: incrementing-address bursts of 1..MAX_LEN
// beats with byte selects, ERR termination and a per-beat ACK timeout.
module wb_burst_master
    import wb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int SEL_W  = selWidth(DATA_W)
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic              iSTART,
    input  logic              iWE,
    input  logic [ADDR_W-1:0] iA,
    input  logic [LEN_W-1:0]  iLEN,
    input  logic [SEL_W-1:0]  iSEL,
    input  logic [DATA_W-1:0] iWDAT,
    output logic              oWREQ,
    output logic [DATA_W-1:0] oRDAT,
    output logic              oRVALID,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oERR,
    output logic              oTIMEOUT,
    output logic [ADDR_W-1:0] oADR,
    output logic [DATA_W-1:0] oDAT,
    input  logic [DATA_W-1:0] iDAT,
    output logic              oWE,
    output logic [SEL_W-1:0]  oSEL,
    output logic              oSTB,
    output logic              oCYC,
    input  logic              iACK,
    input  logic              iERR
);

    stateT             state;
    stateT             nextState;
    logic [ADDR_W-1:0] adrReg;
    logic [DATA_W-1:0] datReg;
    logic [DATA_W-1:0] rdatReg;
    logic [SEL_W-1:0]  selReg;
    logic [LEN_W-1:0]  beatsLeft;
    logic              weReg;
    logic              wreqReg;
    logic              rvalidReg;
    logic              errReg;
    logic              toReg;
    logic              toExpire;
    logic              lastBeat;
    logic              inBeat;

    assign inBeat   = (state == BEAT);
    assign lastBeat = (beatsLeft == LEN_W'(1));

    wb_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) uTimeout (
        .iCLK   (iCLK),
        .iRSTn  (iRSTn),
        .iLoad  (!inBeat || iACK),
        .iInc   (inBeat && !iACK && !iERR),
        .oExpire(toExpire)
    );

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (iSTART) nextState = (iLEN != '0) ? BEAT : DONE;
            BEAT: if (iERR || toExpire || (iACK && lastBeat)) nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            adrReg    <= '0;
            datReg    <= '0;
            rdatReg   <= '0;
            selReg    <= '0;
            beatsLeft <= '0;
            weReg     <= 1'b0;
            wreqReg   <= 1'b0;
            rvalidReg <= 1'b0;
            errReg    <= 1'b0;
            toReg     <= 1'b0;
        end else begin
            wreqReg   <= 1'b0;
            rvalidReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (iSTART) begin
                        errReg <= 1'b0;
                        toReg  <= 1'b0;
                        if (iLEN != '0) begin
                            adrReg    <= iA;
                            weReg     <= iWE;
                            selReg    <= iSEL;
                            beatsLeft <= iLEN;
                            if (iWE) begin
                                datReg  <= iWDAT;
                                wreqReg <= 1'b1;
                            end
                        end
                    end
                end
                BEAT: begin
                    // ERR outranks a simultaneous ACK; timeout aborts the same way.
                    if (iERR || toExpire) begin
                        errReg    <= 1'b1;
                        toReg     <= toExpire;
                        weReg     <= 1'b0;
                        selReg    <= '0;
                        beatsLeft <= '0;
                    end else if (iACK) begin
                        if (!weReg) begin
                            rdatReg   <= iDAT;
                            rvalidReg <= 1'b1;
                        end
                        if (!lastBeat) begin
                            adrReg    <= adrReg + ADDR_W'(SEL_W);
                            beatsLeft <= beatsLeft - 1'b1;
                            if (weReg) begin
                                datReg  <= iWDAT;
                                wreqReg <= 1'b1;
                            end
                        end else begin
                            adrReg    <= '0;
                            datReg    <= '0;
                            weReg     <= 1'b0;
                            selReg    <= '0;
                            beatsLeft <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        oBUSY    = inBeat;
        oDONE    = (state == DONE);
        oCYC     = inBeat;
        oSTB     = inBeat;
        oWE      = inBeat && weReg;
        oSEL     = inBeat ? selReg : '0;
        oADR     = adrReg;
        oDAT     = datReg;
        oRDAT    = rdatReg;
        oRVALID  = rvalidReg;
        oWREQ    = wreqReg;
        oERR     = errReg;
        oTIMEOUT = toReg;
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: table of burst commands against a scripted
// Wishbone slave, plus hand sequences for reset, zero-length and reset mid-burst.
module tb_wb_burst_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 5;
    localparam int SEL_W   = 4;
    localparam int NVEC    = 8;

    logic              iCLK = 1'b0;
    logic              iRSTn = 1'b0;
    logic              iSTART = 1'b0;
    logic              iWE = 1'b0;
    logic [ADDR_W-1:0] iA = '0;
    logic [LEN_W-1:0]  iLEN = '0;
    logic [SEL_W-1:0]  iSEL = '0;
    logic [DATA_W-1:0] iWDAT = '0;
    logic [DATA_W-1:0] iDAT = '0;
    logic              iACK = 1'b0;
    logic              iERR = 1'b0;
    logic              oWREQ, oRVALID, oBUSY, oDONE, oERR, oTIMEOUT;
    logic              oWE, oSTB, oCYC;
    logic [DATA_W-1:0] oRDAT, oDAT;
    logic [ADDR_W-1:0] oADR;
    logic [SEL_W-1:0]  oSEL;

    wb_burst_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iSTART(iSTART), .iWE(iWE), .iA(iA),
        .iLEN(iLEN), .iSEL(iSEL), .iWDAT(iWDAT), .oWREQ(oWREQ), .oRDAT(oRDAT),
        .oRVALID(oRVALID), .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR),
        .oTIMEOUT(oTIMEOUT), .oADR(oADR), .oDAT(oDAT), .iDAT(iDAT), .oWE(oWE),
        .oSEL(oSEL), .oSTB(oSTB), .oCYC(oCYC), .iACK(iACK), .iERR(iERR)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        int          len;
        int          waits;
        int          errBeat;
        bit          noAck;
        int          expStb;
        int          expWreq;
        int          expRv;
        int          expLat;
        bit          expErr;
        bit          expTo;
    } vecT;

    vecT               vecs[NVEC];
    logic [ADDR_W-1:0] adrQ[$];
    logic [DATA_W-1:0] rdQ[$];

    int checks = 0;
    int errors = 0;
    int stbCnt, wreqCnt, rvCnt, doneCnt, wIdx, beatIdx, waitCnt;
    int slvWaits, slvErrBeat;
    bit slvNoAck;
    logic [DATA_W-1:0] rdBase;
    logic [SEL_W-1:0]  curSel;
    logic              curWe;

    function automatic logic [DATA_W-1:0] wordFor(input int i);
        return 32'hDEADBEEF + 32'(i) * 32'h01010101;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then act as the slave
    // and the write-data source for the next rising edge.
    task automatic tick();
        @(negedge iCLK);
        if (oSTB) stbCnt++;
        if (oDONE) doneCnt++;
        if (oWREQ) begin
            wreqCnt++;
            wIdx++;
            iWDAT = wordFor(wIdx);
        end
        if (oRVALID) begin
            rvCnt++;
            if (rdQ.size() == 0) check("rvalid_extra", 64'(1), 64'(0));
            else check("rdat", 64'(oRDAT), 64'(rdQ.pop_front()));
        end
        if (iACK || iERR) begin
            beatIdx++;
            waitCnt = 0;
        end
        iACK = 1'b0;
        iERR = 1'b0;
        if (!oSTB || !iRSTn) begin
            beatIdx = 0;
            waitCnt = 0;
        end else if (!slvNoAck && waitCnt == slvWaits) begin
            if (adrQ.size() == 0) check("adr_extra", 64'(1), 64'(0));
            else check("adr", 64'(oADR), 64'(adrQ.pop_front()));
            check("sel", 64'(oSEL), 64'(curSel));
            check("we", 64'(oWE), 64'(curWe));
            if (curWe) check("wdat", 64'(oDAT), 64'(wordFor(beatIdx)));
            iDAT = rdBase + 32'(beatIdx) + 32'd1;
            iACK = 1'b1;
            if (beatIdx + 1 == slvErrBeat) iERR = 1'b1;
        end else begin
            waitCnt++;
        end
    endtask

    task automatic runCmd(input int k, input logic [DATA_W-1:0] base);
        int presented, acked, lat, done0;
        vecT v;
        v = vecs[k];
        slvWaits   = v.waits;
        slvErrBeat = v.errBeat;
        slvNoAck   = v.noAck;
        rdBase     = base;
        curSel     = 4'hF ^ 4'(k);
        curWe      = v.we;
        presented  = v.noAck ? 0 : ((v.errBeat > 0) ? v.errBeat : v.len);
        acked      = v.noAck ? 0 : ((v.errBeat > 0) ? v.errBeat - 1 : v.len);
        adrQ.delete();
        rdQ.delete();
        for (int b = 0; b < presented; b++) adrQ.push_back(v.adr + 32'(4 * b));
        if (!v.we) for (int b = 0; b < acked; b++) rdQ.push_back(base + 32'(b) + 32'd1);
        stbCnt = 0; wreqCnt = 0; rvCnt = 0; done0 = doneCnt;
        wIdx  = 0;
        iWDAT = wordFor(0);
        iWE   = v.we;
        iA    = v.adr;
        iLEN  = LEN_W'(v.len);
        iSEL  = curSel;
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        lat = 1;
        while (doneCnt == done0 && lat < 200) begin
            tick();
            lat++;
        end
        check($sformatf("v%0d_lat", k), 64'(lat), 64'(v.expLat));
        check($sformatf("v%0d_stb", k), 64'(stbCnt), 64'(v.expStb));
        check($sformatf("v%0d_wreq", k), 64'(wreqCnt), 64'(v.expWreq));
        check($sformatf("v%0d_rvalid", k), 64'(rvCnt), 64'(v.expRv));
        check($sformatf("v%0d_err", k), 64'(oERR), 64'(v.expErr));
        check($sformatf("v%0d_tmo", k), 64'(oTIMEOUT), 64'(v.expTo));
        check($sformatf("v%0d_busy", k), 64'(oBUSY), 64'(0));
        check($sformatf("v%0d_leftover", k), 64'(adrQ.size() + rdQ.size()), 64'(0));
    endtask

    initial begin
        int d0;
        //          we    adr            len wt eb noA stb wrq rv lat err to
        vecs[0] = '{1'b1, 32'h0000_0100, 1, 2, 0, 0,  3,  1, 0,  4, 0, 0};
        vecs[1] = '{1'b0, 32'h0000_0200, 4, 0, 0, 0,  4,  0, 4,  5, 0, 0};
        vecs[2] = '{1'b1, 32'h0000_0300, 3, 0, 2, 0,  2,  2, 0,  3, 1, 0};
        vecs[3] = '{1'b0, 32'h0000_0400, 3, 0, 0, 1,  5,  0, 0,  6, 1, 1};
        vecs[4] = '{1'b1, 32'h0000_0500, 2, 1, 0, 0,  4,  2, 0,  5, 0, 0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 2, 0, 0, 0,  2,  0, 2,  3, 0, 0};
        vecs[6] = '{1'b1, 32'h0000_0600, 4, 4, 0, 0, 20,  4, 0, 21, 0, 0};
        vecs[7] = '{1'b0, 32'h0000_0700, 2, 0, 1, 0,  1,  0, 0,  2, 1, 0};
        slvWaits = 0; slvErrBeat = 0; slvNoAck = 0; rdBase = '0;
        curSel = '0; curWe = 1'b0; doneCnt = 0; beatIdx = 0; waitCnt = 0;
        stbCnt = 0; wreqCnt = 0; rvCnt = 0; wIdx = 0;

        tick();
        tick();
        check("rst_ctl", 64'({oCYC, oSTB, oBUSY, oDONE, oERR, oTIMEOUT, oWREQ, oRVALID, oWE, oSEL}), 64'(0));
        check("rst_adr", 64'(oADR), 64'(0));
        check("rst_dat", 64'({oDAT, oRDAT}), 64'(0));
        iRSTn = 1'b1;
        tick();

        for (int k = 0; k < NVEC; k++) begin
            runCmd(k, (k == 1) ? 32'd0 : (32'(k) << 12));
            tick();
        end

        // Zero-length command: no bus cycle, done next cycle, clears the sticky error.
        stbCnt = 0;
        d0 = doneCnt;
        iLEN = '0;
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        check("len0_done", 64'(doneCnt - d0), 64'(1));
        check("len0_cyc", 64'(stbCnt), 64'(0));
        check("len0_err", 64'(oERR), 64'(0));
        tick();

        // Reset asserted during beat 2 of a 4-beat read.
        adrQ.delete();
        rdQ.delete();
        slvWaits = 0; slvErrBeat = 0; slvNoAck = 0; rdBase = 32'h50;
        curSel = 4'hF; curWe = 1'b0;
        for (int b = 0; b < 2; b++) adrQ.push_back(32'h800 + 32'(4 * b));
        rdQ.push_back(32'h51);
        iWE = 1'b0; iA = 32'h800; iLEN = 8'd4; iSEL = 4'hF;
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        tick();
        #2 iRSTn = 1'b0;
        #1 check("midrst_ctl", 64'({oCYC, oSTB, oBUSY}), 64'(0));
        d0 = doneCnt;
        tick();
        tick();
        iRSTn = 1'b1;
        tick();
        tick();
        check("midrst_nodone", 64'(doneCnt - d0), 64'(0));
        check("midrst_rvalid", 64'(rdQ.size()), 64'(0));
        adrQ.delete();
        rdQ.delete();

        runCmd(1, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
